// File: rtl/scan_display_ctrl.sv
// Multiplexed N-digit 7-segment scan controller with frame-aligned double buffering,
// PWM dimming, leading-zero blanking and decimal points. Option: SCAN_SEG_DECODE_EN adds seg_n.
module scan_display_ctrl #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 50000,
  parameter int BRIGHT_W = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [4*DIGITS-1:0] value,
  input  logic [DIGITS-1:0]   dp_in,
  input  logic                load,
  input  logic                lzb_en,
  input  logic [BRIGHT_W-1:0] bright,
  output logic [DIGITS-1:0]   digit_select,
  output logic [3:0]          nibble,
  output logic                dp_n,
`ifdef SCAN_SEG_DECODE_EN
  output logic [6:0]          seg_n,
`endif
  output logic                frame_done
);
  localparam int PW = $clog2(PRESCALE);
  localparam int SW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int OW = BRIGHT_W + 1 + $clog2(PRESCALE + 1);
  localparam logic [PW-1:0] PCNT_LAST = PW'(PRESCALE - 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(DIGITS - 1);

  logic [PW-1:0]       pcnt_reg, pcnt_next;
  logic [SW-1:0]       slot_reg, slot_next;
  logic [4*DIGITS-1:0] shadow_val_reg, disp_val_reg;
  logic [DIGITS-1:0]   shadow_dp_reg, disp_dp_reg;
  logic [DIGITS-1:0]   digit_select_reg, digit_select_next;
  logic [3:0]          nibble_reg;
  logic                dp_n_reg, dp_n_next;
  logic                frame_done_reg;
  logic                wrap, boundary, blank, lit;
  logic [OW-1:0]       on_time;

  logic [3:0]        slot_nib  [DIGITS];
  logic              lead_zero [DIGITS];
  logic [DIGITS-1:0] slot_dp, slot_hit;
  logic [3:0]        cur_nib;
  logic              cur_dp, cur_lz;

  // lead_zero[k]: slot k and every more-significant slot hold zero
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_slot
      assign slot_nib[gi] = disp_val_reg[4*(DIGITS-gi)-1 -: 4];
      assign slot_dp[gi]  = disp_dp_reg[DIGITS-1-gi];
      assign slot_hit[gi] = (slot_reg == SW'(gi));
      if (gi == 0) begin : g_first
        assign lead_zero[gi] = (slot_nib[gi] == 4'd0);
      end else begin : g_rest
        assign lead_zero[gi] = lead_zero[gi-1] & (slot_nib[gi] == 4'd0);
      end
      assign digit_select_next[gi] = ~(lit & slot_hit[DIGITS-1-gi]);
    end
  endgenerate

  always_comb begin
    cur_nib = 4'd0;
    cur_dp  = 1'b0;
    cur_lz  = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (slot_hit[i]) begin
        cur_nib = slot_nib[i];
        cur_dp  = slot_dp[i];
        cur_lz  = lead_zero[i];
      end
    end
  end

  always_comb begin
    wrap      = (pcnt_reg == PCNT_LAST);
    boundary  = wrap && (slot_reg == SLOT_LAST);
    pcnt_next = wrap ? '0 : pcnt_reg + PW'(1);
    slot_next = slot_reg;
    if (wrap) begin
      slot_next = (slot_reg == SLOT_LAST) ? '0 : slot_reg + SW'(1);
    end
    on_time   = ((OW'(bright) + OW'(1)) * OW'(PRESCALE)) >> BRIGHT_W;
    blank     = lzb_en && cur_lz && (slot_reg != SLOT_LAST) && !cur_dp;
    lit       = (OW'(pcnt_reg) < on_time) && !blank;
    dp_n_next = ~(lit & cur_dp);
  end

`ifdef SCAN_SEG_DECODE_EN
  logic [6:0] seg_n_reg;

  // active-low, bit order gfedcba
  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    case (n)
      4'h0: seg_decode = 7'b1000000;
      4'h1: seg_decode = 7'b1111001;
      4'h2: seg_decode = 7'b0100100;
      4'h3: seg_decode = 7'b0110000;
      4'h4: seg_decode = 7'b0011001;
      4'h5: seg_decode = 7'b0010010;
      4'h6: seg_decode = 7'b0000010;
      4'h7: seg_decode = 7'b1111000;
      4'h8: seg_decode = 7'b0000000;
      4'h9: seg_decode = 7'b0010000;
      4'hA: seg_decode = 7'b0001000;
      4'hB: seg_decode = 7'b0000011;
      4'hC: seg_decode = 7'b1000110;
      4'hD: seg_decode = 7'b0100001;
      4'hE: seg_decode = 7'b0000110;
      default: seg_decode = 7'b0001110;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) seg_n_reg <= 7'h7F;
    else       seg_n_reg <= lit ? seg_decode(cur_nib) : 7'h7F;
  end
  assign seg_n = seg_n_reg;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcnt_reg         <= '0;
      slot_reg         <= '0;
      shadow_val_reg   <= '0;
      shadow_dp_reg    <= '0;
      disp_val_reg     <= '0;
      disp_dp_reg      <= '0;
      digit_select_reg <= '1;
      nibble_reg       <= 4'd0;
      dp_n_reg         <= 1'b1;
      frame_done_reg   <= 1'b0;
    end else begin
      pcnt_reg <= pcnt_next;
      slot_reg <= slot_next;
      if (load) begin
        shadow_val_reg <= value;
        shadow_dp_reg  <= dp_in;
      end
      // a load on this same edge lands in the shadow and waits for the next frame
      if (boundary) begin
        disp_val_reg <= shadow_val_reg;
        disp_dp_reg  <= shadow_dp_reg;
      end
      digit_select_reg <= digit_select_next;
      nibble_reg       <= cur_nib;
      dp_n_reg         <= dp_n_next;
      frame_done_reg   <= boundary;
    end
  end

  assign digit_select = digit_select_reg;
  assign nibble       = nibble_reg;
  assign dp_n         = dp_n_reg;
  assign frame_done   = frame_done_reg;
endmodule

// File: tb/tb_scan_display_ctrl.sv
// Directed bench for scan_display_ctrl at DIGITS=4, PRESCALE=4, BRIGHT_W=2.
module tb_scan_display_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] value = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic        load = 1'b0;
  logic        lzb_en = 1'b0;
  logic [1:0]  bright = 2'd3;
  logic [3:0]  digit_select;
  logic [3:0]  nibble;
  logic        dp_n;
  logic        frame_done;
`ifdef SCAN_SEG_DECODE_EN
  logic [6:0]  seg_n;
  logic [6:0]  cap_seg [16];
`endif

  int total = 0;
  int bad = 0;

  logic [3:0] cap_ds [16];
  logic [3:0] cap_nib [16];
  logic       cap_dp [16];
  logic       cap_fd [16];

  localparam logic [3:0] SEL [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

  scan_display_ctrl #(.DIGITS(4), .PRESCALE(4), .BRIGHT_W(2)) dut (
    .clk(clk),
    .reset(reset),
    .value(value),
    .dp_in(dp_in),
    .load(load),
    .lzb_en(lzb_en),
    .bright(bright),
    .digit_select(digit_select),
    .nibble(nibble),
    .dp_n(dp_n),
`ifdef SCAN_SEG_DECODE_EN
    .seg_n(seg_n),
`endif
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic pulse_load();
    load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  task automatic wait_frame();
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (frame_done !== 1'b1 && n < 40);
    total++;
    if (frame_done !== 1'b1) begin
      bad++;
      $display("FAIL frame_sync frame_done=%b required=1", frame_done);
    end
  endtask

  task automatic capture_frame(input int load_at);
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      cap_ds[i]  = digit_select;
      cap_nib[i] = nibble;
      cap_dp[i]  = dp_n;
      cap_fd[i]  = frame_done;
`ifdef SCAN_SEG_DECODE_EN
      cap_seg[i] = seg_n;
`endif
      load = (i == load_at);
      $display("cyc %0d ds=%b nib=%h dp_n=%b fd=%b load=%b", i, cap_ds[i], cap_nib[i], cap_dp[i], cap_fd[i], load);
    end
    load = 1'b0;
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      total++;
      if (digit_select !== 4'b1111 || nibble !== 4'h0 || dp_n !== 1'b1 || frame_done !== 1'b0) begin
        bad++;
        $display("FAIL reset_state ds=%b nib=%h dp_n=%b fd=%b required 1111/0/1/0", digit_select, nibble, dp_n, frame_done);
      end
`ifdef SCAN_SEG_DECODE_EN
      total++;
      if (seg_n !== 7'h7F) begin
        bad++;
        $display("FAIL reset_seg seg_n=%b required=1111111", seg_n);
      end
`endif
      @(posedge clk); @(posedge clk); #1;
    end
    reset = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_basic_scan();
    bright = 2'd3; lzb_en = 1'b0; dp_in = 4'h0; value = 16'h1234;
    pulse_load();
    wait_frame();
    capture_frame(-1);
    for (int i = 0; i < 16; i++) begin
      total++;
      if (cap_ds[i] !== SEL[i/4] || cap_nib[i] !== 4'(i/4 + 1) || cap_dp[i] !== 1'b1 || cap_fd[i] !== (i == 15)) begin
        bad++;
        $display("FAIL scan_1234[%0d] ds=%b nib=%h dp_n=%b fd=%b required %b/%0d/1/%0d",
                 i, cap_ds[i], cap_nib[i], cap_dp[i], cap_fd[i], SEL[i/4], i/4 + 1, (i == 15));
      end
    end
    $display("test_basic_scan done");
  endtask

  task automatic test_dimming();
    for (int b = 0; b < 2; b++) begin
      bright = 2'(b);
      capture_frame(-1);
      for (int i = 0; i < 16; i++) begin
        logic [3:0] e_ds;
        e_ds = ((i % 4) <= b) ? SEL[i/4] : 4'b1111;
        total++;
        if (cap_ds[i] !== e_ds || cap_nib[i] !== 4'(i/4 + 1) || cap_dp[i] !== 1'b1) begin
          bad++;
          $display("FAIL dim_b%0d[%0d] ds=%b nib=%h dp_n=%b required %b/%0d/1",
                   b, i, cap_ds[i], cap_nib[i], cap_dp[i], e_ds, i/4 + 1);
        end
      end
    end
    bright = 2'd3;
    $display("test_dimming done");
  endtask

  task automatic test_lzb();
    logic [3:0] e_nib [4] = '{4'h0, 4'h0, 4'h5, 4'h0};
    logic [3:0] e_ds_a [4] = '{4'b1111, 4'b1111, 4'b1101, 4'b1110};
    logic [3:0] e_ds_b [4] = '{4'b0111, 4'b1111, 4'b1101, 4'b1110};
    lzb_en = 1'b1; dp_in = 4'b0000; value = 16'h0050;
    pulse_load();
    wait_frame();
    capture_frame(-1);
    for (int i = 0; i < 16; i++) begin
      total++;
      if (cap_ds[i] !== e_ds_a[i/4] || cap_nib[i] !== e_nib[i/4] || cap_dp[i] !== 1'b1) begin
        bad++;
        $display("FAIL lzb_plain[%0d] ds=%b nib=%h dp_n=%b required %b/%h/1",
                 i, cap_ds[i], cap_nib[i], cap_dp[i], e_ds_a[i/4], e_nib[i/4]);
      end
    end
    dp_in = 4'b1000;
    pulse_load();
    wait_frame();
    capture_frame(-1);
    for (int i = 0; i < 16; i++) begin
      total++;
      if (cap_ds[i] !== e_ds_b[i/4] || cap_nib[i] !== e_nib[i/4] || cap_dp[i] !== (i/4 != 0)) begin
        bad++;
        $display("FAIL lzb_dp[%0d] ds=%b nib=%h dp_n=%b required %b/%h/%0d",
                 i, cap_ds[i], cap_nib[i], cap_dp[i], e_ds_b[i/4], e_nib[i/4], (i/4 != 0));
      end
    end
    $display("test_lzb done");
  endtask

  task automatic test_midframe_load();
    logic [3:0] old_nib [4] = '{4'h0, 4'h0, 4'h5, 4'h0};
    lzb_en = 1'b0; value = 16'hAAAA; dp_in = 4'b0000;
    wait_frame();
    capture_frame(5);
    for (int i = 0; i < 16; i++) begin
      total++;
      if (cap_ds[i] !== SEL[i/4] || cap_nib[i] !== old_nib[i/4] || cap_dp[i] !== (i/4 != 0)) begin
        bad++;
        $display("FAIL old_frame[%0d] ds=%b nib=%h dp_n=%b required %b/%h/%0d",
                 i, cap_ds[i], cap_nib[i], cap_dp[i], SEL[i/4], old_nib[i/4], (i/4 != 0));
      end
    end
    capture_frame(-1);
    for (int i = 0; i < 16; i++) begin
      total++;
      if (cap_ds[i] !== SEL[i/4] || cap_nib[i] !== 4'hA || cap_dp[i] !== 1'b1) begin
        bad++;
        $display("FAIL new_frame[%0d] ds=%b nib=%h dp_n=%b required %b/a/1",
                 i, cap_ds[i], cap_nib[i], cap_dp[i], SEL[i/4]);
      end
    end
    $display("test_midframe_load done");
  endtask

  task automatic test_reset_midframe();
    bright = 2'd3; lzb_en = 1'b0;
    wait_frame();
    for (int k = 0; k < 9; k++) @(posedge clk);
    #1;
    total++;
    if (digit_select !== 4'b1101 || nibble !== 4'hA) begin
      bad++;
      $display("FAIL pre_reset ds=%b nib=%h required 1101/a", digit_select, nibble);
    end
    #1 reset = 1'b1;
    #1;
    total++;
    if (digit_select !== 4'b1111 || dp_n !== 1'b1 || nibble !== 4'h0 || frame_done !== 1'b0) begin
      bad++;
      $display("FAIL async_reset ds=%b dp_n=%b nib=%h fd=%b required 1111/1/0/0", digit_select, dp_n, nibble, frame_done);
    end
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    capture_frame(-1);
    for (int i = 0; i < 16; i++) begin
      total++;
      if (cap_ds[i] !== SEL[i/4] || cap_nib[i] !== 4'h0 || cap_dp[i] !== 1'b1 || cap_fd[i] !== (i == 15)) begin
        bad++;
        $display("FAIL after_reset[%0d] ds=%b nib=%h dp_n=%b fd=%b required %b/0/1/%0d",
                 i, cap_ds[i], cap_nib[i], cap_dp[i], cap_fd[i], SEL[i/4], (i == 15));
      end
    end
    $display("test_reset_midframe done");
  endtask

`ifdef SCAN_SEG_DECODE_EN
  task automatic test_seg_decode();
    logic [6:0] lit_seg [4] = '{7'b0000000, 7'b1111001, 7'b1000000, 7'b1000000};
    value = 16'h8100; dp_in = 4'h0; lzb_en = 1'b0; bright = 2'd0;
    pulse_load();
    wait_frame();
    capture_frame(-1);
    for (int i = 0; i < 16; i++) begin
      logic [6:0] e_seg;
      e_seg = (i % 4 == 0) ? lit_seg[i/4] : 7'b1111111;
      total++;
      if (cap_seg[i] !== e_seg) begin
        bad++;
        $display("FAIL seg_decode[%0d] seg_n=%b required=%b", i, cap_seg[i], e_seg);
      end
    end
    bright = 2'd3;
    $display("test_seg_decode done");
  endtask
`endif

  initial begin
    test_reset();
    test_basic_scan();
    test_dimming();
    test_lzb();
    test_midframe_load();
    test_reset_midframe();
`ifdef SCAN_SEG_DECODE_EN
    test_seg_decode();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
